// File: rtl/duty_cycle_controller.sv
// Duty-cycle setpoint controller driven by two push-buttons (up/down).
// Each button is synchronized, debounced, and run through a small
// press/auto-repeat state machine. Every event steps the duty value
// by STEP, and the result saturates at 0 and 255.
//
// Per-button state machine:
//   state  | meaning
//   IDLE   | button released (or both held); waiting for a press edge
//   DELAY  | press accepted; timing the hold before auto-repeat starts
//   REPEAT | auto-repeat active; one event per REPEAT_PERIOD cycles
module duty_cycle_controller #(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd1000000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd10000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000,
  parameter logic [7:0]  STEP            = 8'd25,
  parameter logic [7:0]  INIT_DUTY       = 8'd128
) (
  input  logic       Clock_in,
  input  logic       Reset,
  input  logic       Button_up,
  input  logic       Button_down,
  output logic [7:0] Duty_cycle,
  output logic       Duty_changed
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;

  // Index 0 is the up button and index 1 is the down button.
  logic [1:0]  raw;
  logic [1:0]  sync1, sync2;
  logic [1:0]  deb, deb_prev;
  logic [23:0] db_cnt [2];
  btn_state_t  state [2];
  btn_state_t  state_nxt [2];
  logic [23:0] timer [2];
  logic [23:0] timer_nxt [2];
  logic [1:0]  evt;
  logic        both_held;
  logic [8:0]  sum_up;
  logic signed [8:0] diff_dn;
  logic [7:0]  duty_nxt;

  assign raw       = {Button_down, Button_up};
  assign both_held = deb[0] & deb[1];

  // Synchronize the raw buttons and debounce them. A mismatch only counts
  // while it is uninterrupted.
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEBOUNCE_CYCLES - 24'd1) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end
      end
    end
  end

  // Register the per-button state and its hold/repeat down-counter.
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_nxt[i];
        timer[i] <= timer_nxt[i];
      end
    end
  end

  // Compute the next state and timer, and raise a one-cycle event on a press,
  // when the hold delay expires, or on each repeat tick.
  always_comb begin
    evt = '0;
    for (int i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      timer_nxt[i] = timer[i];
      if (both_held) begin
        // Holding both buttons is ambiguous, so park both machines until
        // one button is released and pressed again.
        state_nxt[i] = IDLE;
        timer_nxt[i] = '0;
      end else begin
        case (state[i])
          IDLE: begin
            if (deb[i] && !deb_prev[i]) begin
              evt[i]       = 1'b1;
              state_nxt[i] = DELAY;
              timer_nxt[i] = REPEAT_DELAY - 24'd1;
            end
          end
          DELAY: begin
            if (!deb[i]) begin
              state_nxt[i] = IDLE;
              timer_nxt[i] = '0;
            end else if (timer[i] == 24'd0) begin
              evt[i]       = 1'b1;
              state_nxt[i] = REPEAT;
              timer_nxt[i] = REPEAT_PERIOD - 24'd1;
            end else begin
              timer_nxt[i] = timer[i] - 24'd1;
            end
          end
          REPEAT: begin
            if (!deb[i]) begin
              state_nxt[i] = IDLE;
              timer_nxt[i] = '0;
            end else if (timer[i] == 24'd0) begin
              evt[i]       = 1'b1;
              timer_nxt[i] = REPEAT_PERIOD - 24'd1;
            end else begin
              timer_nxt[i] = timer[i] - 24'd1;
            end
          end
          default: begin
            state_nxt[i] = IDLE;
            timer_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  assign sum_up  = {1'b0, Duty_cycle} + {1'b0, STEP};
  assign diff_dn = $signed({1'b0, Duty_cycle}) - $signed({1'b0, STEP});

  // Apply a saturating step. Simultaneous up and down events cancel out.
  always_comb begin
    duty_nxt = Duty_cycle;
    case (evt)
      2'b01:   duty_nxt = sum_up[8] ? 8'hFF : sum_up[7:0];
      2'b10:   duty_nxt = diff_dn[8] ? 8'h00 : diff_dn[7:0];
      default: duty_nxt = Duty_cycle;
    endcase
  end

  // Register the duty value and pulse Duty_changed only on a real change.
  always_ff @(posedge Clock_in or posedge Reset) begin
    if (Reset) begin
      Duty_cycle   <= INIT_DUTY;
      Duty_changed <= 1'b0;
    end else begin
      Duty_cycle   <= duty_nxt;
      Duty_changed <= (duty_nxt != Duty_cycle);
    end
  end

endmodule

// File: tb/tb_duty_cycle_controller.sv
// Directed bench for duty_cycle_controller with short debounce/repeat timing.
module tb_duty_cycle_controller;

  logic       Clock_in = 1'b0;
  logic       Reset = 1'b1;
  logic       Button_up = 1'b0;
  logic       Button_down = 1'b0;
  logic [7:0] Duty_cycle;
  logic       Duty_changed;

  int tests = 0;
  int failures = 0;
  int pulses = 0;
  int p0;
  int exp_duty;
  int old_duty;

  duty_cycle_controller #(
    .DEBOUNCE_CYCLES(24'd4),
    .REPEAT_DELAY   (24'd20),
    .REPEAT_PERIOD  (24'd8),
    .STEP           (8'd25),
    .INIT_DUTY      (8'd128)
  ) dut (
    .Clock_in    (Clock_in),
    .Reset       (Reset),
    .Button_up   (Button_up),
    .Button_down (Button_down),
    .Duty_cycle  (Duty_cycle),
    .Duty_changed(Duty_changed)
  );

  always #5 Clock_in = ~Clock_in;

  // Count Duty_changed pulses, sampled away from the active edge.
  always @(negedge Clock_in) if (Duty_changed === 1'b1) pulses++;

  task automatic tick();
    @(posedge Clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Power-on reset
    repeat (3) tick();
    chk("reset_duty", Duty_cycle, 128);
    chk("reset_chg", Duty_changed, 0);
    Reset = 1'b0;

    // Single tap of up: update at edge N+7, one pulse only
    tick();
    p0 = pulses;
    Button_up = 1'b1;
    repeat (6) tick();
    chk("tap_before", Duty_cycle, 128);
    tick();
    chk("tap_duty", Duty_cycle, 153);
    chk("tap_chg", Duty_changed, 1);
    tick();
    chk("tap_chg_off", Duty_changed, 0);
    repeat (2) tick();
    Button_up = 1'b0;
    repeat (30) tick();
    chk("tap_hold", Duty_cycle, 153);
    chk("tap_pulses", pulses - p0, 1);

    // Asynchronous reset asserted mid-cycle
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_duty", Duty_cycle, 128);
    chk("async_rst_chg", Duty_changed, 0);
    tick();
    Reset = 1'b0;

    // Glitches shorter than the debounce window are ignored
    tick();
    p0 = pulses;
    Button_up = 1'b1; repeat (3) tick();
    Button_up = 1'b0; repeat (3) tick();
    Button_up = 1'b1; repeat (3) tick();
    Button_up = 1'b0; repeat (20) tick();
    chk("glitch_duty", Duty_cycle, 128);
    chk("glitch_pulses", pulses - p0, 0);

    // Hold up for 200 cycles: press, delay, then auto-repeat to saturation
    p0 = pulses;
    exp_duty = 128;
    Button_up = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      old_duty = exp_duty;
      if (t == 7) exp_duty = 153;
      else if (t >= 27 && ((t - 27) % 8) == 0)
        exp_duty = (exp_duty + 25 > 255) ? 255 : exp_duty + 25;
      chk($sformatf("hold_duty_t%0d", t), Duty_cycle, exp_duty);
      chk($sformatf("hold_chg_t%0d", t), Duty_changed, (exp_duty != old_duty) ? 1 : 0);
    end
    Button_up = 1'b0;
    repeat (30) tick();
    chk("hold_final", Duty_cycle, 255);
    chk("hold_pulses", pulses - p0, 6);

    // Reset back to 128, then tap down seven times
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    chk("rst2_duty", Duty_cycle, 128);
    p0 = pulses;
    exp_duty = 128;
    for (int k = 0; k < 7; k++) begin
      old_duty = exp_duty;
      exp_duty = (exp_duty < 25) ? 0 : exp_duty - 25;
      Button_down = 1'b1;
      repeat (7) tick();
      chk($sformatf("down_duty_%0d", k), Duty_cycle, exp_duty);
      chk($sformatf("down_chg_%0d", k), Duty_changed, (exp_duty != old_duty) ? 1 : 0);
      tick();
      Button_down = 1'b0;
      repeat (12) tick();
    end
    chk("down_final", Duty_cycle, 0);
    chk("down_pulses", pulses - p0, 6);

    // Both buttons pressed together: no change
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    p0 = pulses;
    Button_up = 1'b1;
    Button_down = 1'b1;
    repeat (40) tick();
    chk("both_duty", Duty_cycle, 128);
    chk("both_pulses", pulses - p0, 0);
    Button_up = 1'b0;
    Button_down = 1'b0;
    repeat (12) tick();
    chk("both_after", Duty_cycle, 128);

    // Reset pulsed while up is held: a fresh press after full debounce
    Button_up = 1'b1;
    repeat (10) tick();
    chk("held_pre", Duty_cycle, 153);
    Reset = 1'b1;
    tick();
    chk("held_rst", Duty_cycle, 128);
    Reset = 1'b0;
    repeat (6) tick();
    chk("held_before", Duty_cycle, 128);
    tick();
    chk("held_after", Duty_cycle, 153);
    chk("held_chg", Duty_changed, 1);
    Button_up = 1'b0;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
